// File: rtl/adder_share_arb.sv
// Purpose: round-robin arbiter sharing one registered W-bit carry-lookahead adder among NREQ requesters.
// Latency: a grant in cycle t gives rsp_valid in cycle t+2; each stalled cycle adds one.
// Backpressure: rsp_valid && !rsp_ready freezes both stages and the pointer, and forces gnt to 0.
module adder_share_arb #(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ-1:0]   cin_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_sum
);

  // Pointer to the last winner; the search starts one past it.
  logic [IDW-1:0] ptr_q, ptr_d;

  // Stage 1: operands of the granted requester.
  logic           s1_v_q, s1_v_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [W-1:0]   s1_a_q, s1_a_d;
  logic [W-1:0]   s1_b_q, s1_b_d;
  logic           s1_cin_q, s1_cin_d;

  // Stage 2: response register.
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W:0]     rsp_sum_q, rsp_sum_d;

  logic           en;
  logic           win_vld;
  logic           gnt_vld;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;

  logic [W-1:0]   gen;
  logic [W-1:0]   prop;
  logic [W:0]     carry;
  logic           term;
  logic           cy;
  logic [W:0]     cla_sum;

  // The whole pipeline moves together: only when the response slot is free or being taken.
  assign en = !rsp_valid_q || rsp_ready;

  // Rotating-priority search from ptr+1; the pointer itself is checked last so a lone requester can win again.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    gnt     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    gnt_vld = win_vld && en && rst_n;
    if (gnt_vld) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // Carry-lookahead: every carry is a flat sum of generate/propagate products, no carry chain.
  always_comb begin
    gen      = s1_a_q & s1_b_q;
    prop     = s1_a_q ^ s1_b_q;
    carry    = '0;
    carry[0] = s1_cin_q;
    term     = 1'b0;
    cy       = 1'b0;
    for (int i = 1; i <= W; i++) begin
      term = s1_cin_q;
      for (int k = 0; k < i; k++) begin
        term = term & prop[k];
      end
      cy = term;
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & prop[k];
        end
        cy = cy | term;
      end
      carry[i] = cy;
    end
    cla_sum = {carry[W], prop ^ carry[W-1:0]};
  end

  // Next-state: capture the winner into stage 1 and the adder result into stage 2 when enabled.
  always_comb begin
    ptr_d       = ptr_q;
    s1_v_d      = s1_v_q;
    s1_id_d     = s1_id_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_cin_d    = s1_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    if (en) begin
      s1_v_d = gnt_vld;
      if (gnt_vld) begin
        ptr_d    = win_idx;
        s1_id_d  = win_idx;
        s1_a_d   = a_in[int'(win_idx)*W +: W];
        s1_b_d   = b_in[int'(win_idx)*W +: W];
        s1_cin_d = cin_in[win_idx];
      end
      rsp_valid_d = s1_v_q;
      if (s1_v_q) begin
        rsp_id_d  = s1_id_q;
        rsp_sum_d = cla_sum;
      end
    end
  end

  // State registers; reset discards anything in flight and gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IDW'(NREQ - 1);
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule
